// File: rtl/leg_mem_pkg.sv
// leg_mem_pkg: shared types, HSIZE encodings and alignment rule for the memory port arbiter.
package leg_mem_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;
   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;
   function automatic logic is_aligned(input logic [1:0] addr, input logic [2:0] size);
      return size[1:0] != 2'b11 && !(size == HSIZE_HALF && addr[0]) && !(size == HSIZE_WORD && addr != 2'b00);
   endfunction
endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: D-over-I grant select with a saturating starvation counter that lets I win.
module mem_arb_priority #(
   parameter int MAX_STARVE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_req,
   input  logic d_req,
   input  logic grant_strobe,
   output logic grant_i,
   output logic grant_d
);
   logic [7:0] starve_q, starve_d;
   logic       starved;
   always_comb begin
      starved  = starve_q == 8'(MAX_STARVE);
      grant_i  = i_req && (!d_req || starved);
      grant_d  = d_req && !grant_i;
      starve_d = (grant_strobe && grant_i) ? 8'd0 :
                 (grant_strobe && grant_d && i_req && !starved) ? starve_q + 8'd1 : starve_q;
   end
   always_ff @(posedge clk) begin
      if (reset) starve_q <= 8'd0;
      else       starve_q <= starve_d;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and data (D) requesters,
// sequencing each access with WAIT_STATES extra cycles and a one-cycle completion pulse.
module mem_port_arbiter
   import leg_mem_pkg::*;
#(
   parameter int WAIT_STATES = 0,
   parameter int MAX_STARVE  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rd,
   output logic        i_valid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wd,
   input  logic [2:0]  d_size,
   output logic [31:0] d_rd,
   output logic        d_valid,
   output logic        d_err,
   output logic        m_hsel,
   output logic        m_re,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wd,
   output logic [2:0]  m_hsize,
   input  logic [31:0] m_rd
);
   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   logic        we_q, we_d, err_q, err_d;
   logic [3:0]  wait_q, wait_d;
   logic [31:0] addr_q, addr_d, wd_q, wd_d, i_rd_q, i_rd_d, d_rd_q, d_rd_d;
   logic [2:0]  hsize_q, hsize_d;
   logic        grant_i, grant_d, grant_strobe, last, acc, resp, d_bad;
   mem_arb_priority #(.MAX_STARVE(MAX_STARVE)) u_prio (
      .clk(clk), .reset(reset), .i_req(i_req), .d_req(d_req),
      .grant_strobe(grant_strobe), .grant_i(grant_i), .grant_d(grant_d)
   );
   always_comb begin
      grant_strobe = state_q == IDLE && (i_req || d_req);
      last    = wait_q == 4'(WAIT_STATES);
      d_bad   = !is_aligned(d_addr[1:0], d_size);
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      err_d   = err_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      hsize_d = hsize_q;
      i_rd_d  = i_rd_q;
      d_rd_d  = d_rd_q;
      case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d = ACCESS;
               owner_d = OWN_I;
               we_d    = 1'b0;
               err_d   = 1'b0;
               wait_d  = 4'd0;
               addr_d  = i_addr & ~32'h3;
               wd_d    = 32'd0;
               hsize_d = HSIZE_WORD;
            end else if (grant_d) begin
               state_d = d_bad ? RESP : ACCESS;
               owner_d = OWN_D;
               we_d    = d_we;
               err_d   = d_bad;
               wait_d  = 4'd0;
               addr_d  = d_addr;
               wd_d    = d_wd;
               hsize_d = d_size;
            end
         end
         ACCESS: begin
            wait_d  = last ? wait_q : wait_q + 4'd1;
            state_d = last ? RESP : ACCESS;
            i_rd_d  = (last && owner_q == OWN_I) ? m_rd : i_rd_q;
            d_rd_d  = (last && owner_q == OWN_D) ? m_rd : d_rd_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWN_I;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         wait_q  <= 4'd0;
         addr_q  <= 32'd0;
         wd_q    <= 32'd0;
         hsize_q <= 3'd0;
         i_rd_q  <= 32'd0;
         d_rd_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         hsize_q <= hsize_d;
         i_rd_q  <= i_rd_d;
         d_rd_q  <= d_rd_d;
      end
   end
   // The write strobe sees reset combinationally so a reset in the final cycle commits nothing.
   always_comb begin
      acc     = state_q == ACCESS;
      resp    = state_q == RESP;
      m_hsel  = acc;
      m_re    = acc && !we_q;
      m_we    = acc && we_q && last && !reset;
      m_addr  = acc ? addr_q : 32'd0;
      m_wd    = acc ? wd_q : 32'd0;
      m_hsize = acc ? hsize_q : 3'd0;
      i_valid = resp && owner_q == OWN_I;
      d_valid = resp && owner_q == OWN_D;
      d_err   = resp && owner_q == OWN_D && err_q;
      i_rd    = i_rd_q;
      d_rd    = d_rd_q;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions against a byte-array memory model.
module tb_mem_port_arbiter;
   localparam int WS = 2;
   localparam int MS = 4;
   logic        clk = 0, reset = 1, mem_clr = 1;
   logic        i_req = 0, i_valid, d_req = 0, d_we = 0, d_valid, d_err;
   logic [31:0] i_addr = 0, i_rd, d_addr = 0, d_wd = 0, d_rd;
   logic [2:0]  d_size = 0, m_hsize;
   logic        m_hsel, m_re, m_we;
   logic [31:0] m_addr, m_wd, m_rd;
   logic [7:0]  mem [1024];
   logic [7:0]  ref_mem [1024];
   int          checks = 0, passes = 0;
   always #5 clk = ~clk;
   mem_port_arbiter #(.WAIT_STATES(WS), .MAX_STARVE(MS)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rd(i_rd), .i_valid(i_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd), .d_size(d_size),
      .d_rd(d_rd), .d_valid(d_valid), .d_err(d_err),
      .m_hsel(m_hsel), .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd),
      .m_hsize(m_hsize), .m_rd(m_rd)
   );
   function automatic bit lane(input logic [1:0] a, input logic [2:0] s, input int b);
      return s[1:0] == 2'b10 ? 1'b1 : s[1:0] == 2'b01 ? (b / 2 == int'(a[1])) : (b == int'(a));
   endfunction
   assign m_rd = {mem[{m_addr[9:2], 2'd3}], mem[{m_addr[9:2], 2'd2}], mem[{m_addr[9:2], 2'd1}], mem[{m_addr[9:2], 2'd0}]};
   always @(posedge clk) begin
      if (mem_clr) for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
      else if (m_we) for (int b = 0; b < 4; b++) if (lane(m_addr[1:0], m_hsize, b)) mem[{m_addr[9:2], 2'(b)}] <= m_wd[8*b +: 8];
   end
   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return {ref_mem[{a[9:2], 2'd3}], ref_mem[{a[9:2], 2'd2}], ref_mem[{a[9:2], 2'd1}], ref_mem[{a[9:2], 2'd0}]};
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] size);
      bit legal;
      int n, hs, re, wr, wr_at, iv;
      logic got, err;
      logic [31:0] exp_rd;
      legal = size[1:0] != 2'b11 && !(size == 3'b001 && addr[0]) && !(size == 3'b010 && addr[1:0] != 2'b00);
      exp_rd = ref_word(addr);
      n = 0; hs = 0; re = 0; wr = 0; wr_at = 0; iv = 0; got = 0; err = 0;
      d_we = we; d_addr = addr; d_wd = wd; d_size = size; d_req = 1;
      while (!got && n < 64) begin
         tick();
         n++;
         hs += int'(m_hsel);
         re += int'(m_re);
         if (m_we) begin wr++; wr_at = n; end
         iv += int'(i_valid);
         got = d_valid;
         err = d_err;
      end
      d_req = 0;
      checks++; if (n !== (legal ? WS + 2 : 1)) $display("FAIL d_latency addr=%h got=%0d exp=%0d", addr, n, legal ? WS + 2 : 1); else passes++;
      checks++; if (err !== !legal) $display("FAIL d_err addr=%h size=%0d got=%b exp=%b", addr, size, err, !legal); else passes++;
      checks++; if (hs !== (legal ? WS + 1 : 0)) $display("FAIL d_hsel_cycles addr=%h got=%0d exp=%0d", addr, hs, legal ? WS + 1 : 0); else passes++;
      checks++; if (iv !== 0) $display("FAIL d_stray_i_valid got=%0d exp=0", iv); else passes++;
      if (legal && we) begin
         checks++; if (wr !== 1 || wr_at !== WS + 1 || re !== 0) $display("FAIL d_write_strobe wr=%0d at=%0d re=%0d exp=1 at %0d re 0", wr, wr_at, re, WS + 1); else passes++;
         for (int b = 0; b < 4; b++) if (lane(addr[1:0], size, b)) ref_mem[{addr[9:2], 2'(b)}] = wd[8*b +: 8];
      end else if (legal) begin
         checks++; if (re !== WS + 1 || wr !== 0) $display("FAIL d_read_strobe re=%0d wr=%0d exp=%0d 0", re, wr, WS + 1); else passes++;
         checks++; if (d_rd !== exp_rd) $display("FAIL d_rd addr=%h got=%h exp=%h", addr, d_rd, exp_rd); else passes++;
      end else begin
         checks++; if (re !== 0 || wr !== 0) $display("FAIL d_err_no_mem re=%0d wr=%0d exp=0 0", re, wr); else passes++;
      end
      tick();
      checks++; if (d_valid !== 1'b0) $display("FAIL d_valid_pulse got=%b exp=0", d_valid); else passes++;
   endtask
   task automatic i_txn(input logic [31:0] addr);
      int n, hs, wr, dv;
      logic got;
      logic [31:0] ma, exp_rd;
      logic [2:0] mh;
      n = 0; hs = 0; wr = 0; dv = 0; got = 0; ma = 0; mh = 0;
      exp_rd = ref_word(addr);
      i_addr = addr; i_req = 1;
      while (!got && n < 64) begin
         tick();
         n++;
         if (m_hsel) begin
            if (hs == 0) begin ma = m_addr; mh = m_hsize; end
            hs++;
         end
         wr += int'(m_we);
         dv += int'(d_valid);
         got = i_valid;
      end
      i_req = 0;
      checks++; if (n !== WS + 2) $display("FAIL i_latency got=%0d exp=%0d", n, WS + 2); else passes++;
      checks++; if (ma !== {addr[31:2], 2'b00} || mh !== 3'b010) $display("FAIL i_port addr=%h hsize=%0d exp=%h 2", ma, mh, {addr[31:2], 2'b00}); else passes++;
      checks++; if (hs !== WS + 1 || wr !== 0 || dv !== 0) $display("FAIL i_strobes hsel=%0d we=%0d dvalid=%0d exp=%0d 0 0", hs, wr, dv, WS + 1); else passes++;
      checks++; if (i_rd !== exp_rd) $display("FAIL i_rd addr=%h got=%h exp=%h", addr, i_rd, exp_rd); else passes++;
      tick();
      checks++; if (i_valid !== 1'b0) $display("FAIL i_valid_pulse got=%b exp=0", i_valid); else passes++;
   endtask
   task automatic test_reset;
      reset = 1;
      repeat (2) tick();
      checks++; if ({m_hsel, m_re, m_we, m_addr, m_wd, m_hsize, i_valid, i_rd, d_valid, d_rd, d_err} !== '0)
         $display("FAIL reset_outputs got=%h exp=0", {m_hsel, m_re, m_we, m_addr, m_wd, m_hsize, i_valid, i_rd, d_valid, d_rd, d_err}); else passes++;
      reset = 0;
      tick();
   endtask
   task automatic test_write_read;
      d_txn(1, 32'h100, 32'hDEADBEEF, 3'b010);
      d_txn(0, 32'h100, 32'h0, 3'b010);
      checks++; if (d_rd !== 32'hDEADBEEF) $display("FAIL word_readback got=%h exp=deadbeef", d_rd); else passes++;
   endtask
   task automatic test_byte_write;
      d_txn(1, 32'h100, 32'h11223344, 3'b010);
      d_txn(1, 32'h101, 32'h0000AB00, 3'b000);
      d_txn(0, 32'h100, 32'h0, 3'b010);
      checks++; if (d_rd !== 32'h1122AB44) $display("FAIL byte_merge got=%h exp=1122ab44", d_rd); else passes++;
      d_txn(1, 32'h102, 32'h55660000, 3'b001);
      d_txn(0, 32'h100, 32'h0, 3'b010);
   endtask
   task automatic test_illegal;
      d_txn(0, 32'h102, 32'h0, 3'b010);
      d_txn(1, 32'h103, 32'hFFFF_FFFF, 3'b001);
      d_txn(1, 32'h100, 32'hFFFF_FFFF, 3'b011);
      d_txn(0, 32'h100, 32'h0, 3'b010);
   endtask
   task automatic test_ifetch;
      d_txn(1, 32'h200, 32'h5A5AA5A5, 3'b010);
      i_txn(32'h203);
   endtask
   task automatic test_reset_midflight;
      d_txn(1, 32'h200, 32'h0, 3'b010);
      d_we = 1; d_addr = 32'h200; d_wd = 32'hCAFEF00D; d_size = 3'b010; d_req = 1;
      repeat (WS + 1) tick();
      checks++; if (m_we !== 1'b1) $display("FAIL final_cycle_we got=%b exp=1", m_we); else passes++;
      reset = 1; d_req = 0;
      #1;
      checks++; if (m_we !== 1'b0) $display("FAIL reset_gates_we got=%b exp=0", m_we); else passes++;
      tick();
      checks++; if ({m_hsel, m_re, m_we, m_addr, m_wd, m_hsize, i_valid, d_valid, d_err, d_rd} !== '0)
         $display("FAIL midflight_outputs got=%h exp=0", {m_hsel, m_re, m_we, m_addr, m_wd, m_hsize, i_valid, d_valid, d_err, d_rd}); else passes++;
      checks++; if ({mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]} !== 32'h0) $display("FAIL midflight_mem got=%h exp=0", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}); else passes++;
      reset = 0;
      tick();
      d_txn(0, 32'h200, 32'h0, 3'b010);
   endtask
   task automatic test_starve;
      int cnt, seen, n, both, wide;
      bit pv;
      string got_s, exp_s;
      cnt = 0; seen = 0; n = 0; both = 0; wide = 0; pv = 0; got_s = ""; exp_s = "";
      reset = 1;
      tick();
      reset = 0;
      i_addr = 32'h104; d_we = 0; d_addr = 32'h100; d_size = 3'b010; i_req = 1; d_req = 1;
      while (seen < 10 && n < 300) begin
         tick();
         n++;
         if (i_valid && d_valid) both++;
         if ((i_valid || d_valid) && pv) wide++;
         pv = i_valid || d_valid;
         if (i_valid || d_valid) begin
            if (cnt == MS) begin exp_s = {exp_s, "I"}; cnt = 0; end
            else begin exp_s = {exp_s, "D"}; cnt++; end
            got_s = {got_s, i_valid ? "I" : "D"};
            seen++;
            if (i_valid) begin
               checks++; if (i_rd !== ref_word(32'h104)) $display("FAIL starve_i_rd got=%h exp=%h", i_rd, ref_word(32'h104)); else passes++;
            end
         end
      end
      i_req = 0; d_req = 0;
      repeat (2) tick();
      checks++; if (got_s != exp_s) $display("FAIL grant_order got=%s exp=%s", got_s, exp_s); else passes++;
      checks++; if (both !== 0 || wide !== 0) $display("FAIL valid_pulses coincident=%0d wide=%0d exp=0 0", both, wide); else passes++;
   endtask
   task automatic test_random;
      logic [31:0] a;
      logic [2:0] s;
      for (int t = 0; t < 40; t++) begin
         a = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 9) < 3) i_txn(a);
         else begin
            s = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a = s == 3'b010 ? a & ~32'h3 : s == 3'b001 ? a & ~32'h1 : a;
            d_txn(1'($urandom_range(0, 1)), a, $urandom, s);
         end
      end
   endtask
   initial begin
      for (int k = 0; k < 1024; k++) ref_mem[k] = 8'h00;
      repeat (2) tick();
      mem_clr = 0;
      test_reset();
      test_write_read();
      test_byte_write();
      test_illegal();
      test_ifetch();
      test_reset_midflight();
      test_starve();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
